timer_cmp: RTL and testbench
============================

TIMER_CMP -- requirements
Module: timer_cmp

Interface
REQ-001 The block SHALL have these ports, one per line:
- clk  in  1  clock; all state updates on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- time_lo  in  32  low half of time, from the low time counter.
- time_carry  in  1  carry bit of the low counter; toggles once per low-half wrap.
- csr_en  in  1  CSR access strobe, one cycle.
- csr_sel  in  2  target: 00 cmp_lo, 01 cmp_hi, 10 time_hi, 11 reserved.
- rw_mode  in  2  00 read, 01 write, 10 set, 11 clear.
- d  in  32  CSR write operand.
- irq_en  in  1  timer interrupt enable.
- qo  out  32  read data of the selected register.
- time_hi  out  32  upper half of the 64-bit time.
- mtip  out  1  machine timer interrupt pending, registered.

Function
REQ-002 The block SHALL hold the registers cmp_lo[31:0], cmp_hi[31:0], time_hi[31:0] and carry_prev (1 bit).
REQ-003 The block SHALL generate a wrap event, combinationally, as time_carry XOR carry_prev.
REQ-004 carry_prev SHALL load time_carry on every clock edge.
REQ-005 On the edge that ends a cycle with a wrap event, time_hi SHALL increment by 1, modulo 2^32.
- Result: {time_hi,time_lo} steps from {h,FFFFFFFF} to {h+1,00000000} on the same edge.
REQ-006 time_hi SHALL wrap from FFFFFFFF to 00000000 with no flag and no side effect.
REQ-007 A CSR update SHALL occur only when csr_en=1 and rw_mode!=00. The new value of the target register is:
- 01: d.
- 10: reg | d.
- 11: reg & ~d.
REQ-008 rw_mode=00 SHALL leave all registers unchanged.
REQ-009 Writes with csr_sel=11 SHALL be ignored.
REQ-010 A CSR write to time_hi on the same edge as a wrap increment SHALL win; the increment for that edge is discarded.
REQ-011 qo SHALL be combinational: the pre-update value of the selected register, or 0 when csr_sel=11.
- qo does not depend on csr_en.
REQ-012 The block SHALL evaluate the compare as cmp_ge = ({time_hi,time_lo} >= {cmp_hi,cmp_lo}).
- Unsigned 64-bit compare.
- Uses the current-cycle register and input values.
REQ-013 mtip SHALL load (irq_en & cmp_ge) each edge, giving 1 cycle latency from the compare condition.
REQ-014 On an edge where a CSR update targets cmp_lo or cmp_hi, mtip SHALL load 0.
- It is re-evaluated with the new compare value on the following edge.
REQ-015 Deasserting irq_en SHALL clear mtip on the next edge.
REQ-016 mtip SHALL be level-sensitive with no latching.
- It stays 1 while the condition holds.
- It is cleared only by the condition going false, a compare write, or irq_en=0.

Reset
REQ-017 While nreset=0, the block SHALL hold:
- cmp_lo = FFFFFFFF and cmp_hi = FFFFFFFF.
- time_hi = 0, carry_prev = 0, mtip = 0.
- qo reflecting these values per csr_sel.
REQ-018 Reset SHALL take effect asynchronously and SHALL abort any in-flight CSR update or wrap increment.
REQ-019 The block SHALL resume normal operation on the first rising edge after nreset rises.
- time_carry=0 after reset is not treated as a wrap event.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then csr_sel=00/01/10/11 -> qo = FFFFFFFF / FFFFFFFF / 00000000 / 00000000; mtip=0.
- time_carry 0->1 with time_lo=FFFFFFFF -> time_hi 0->1 on the next edge, coincident with time_lo=0; carry held at 1 gives no further increment; carry 1->0 later -> time_hi=2.
- Write cmp_hi=0, then cmp_lo=10, irq_en=1, time_hi=0, time_lo ramping -> mtip rises 1 cycle after time_lo reaches 0x10, and mtip=0 on each cmp write edge.
- With mtip=1: set-mode cmp_hi |= 1 -> mtip=0 on the write edge and stays 0; clear-mode cmp_hi &= ~1 -> mtip=1 again two edges later.
- Write time_hi=0x1234 on the same edge as a wrap event -> time_hi=0x1234, not 0x1235; irq_en=0 with cmp_ge true -> mtip=0 next edge.
- Assert nreset mid-write to cmp_lo -> cmp_lo=FFFFFFFF and mtip=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/timer_cmp.sv
// Upper half of the 64-bit machine timer, the 64-bit compare register, and the
// registered timer interrupt, with read/write/set/clear CSR access.
module timer_cmp (
   input  logic        clk,
   input  logic        nreset,
   input  logic [31:0] time_lo,
   input  logic        time_carry,
   input  logic        csr_en,
   input  logic [1:0]  csr_sel,
   input  logic [1:0]  rw_mode,
   input  logic [31:0] d,
   input  logic        irq_en,
   output logic [31:0] qo,
   output logic [31:0] time_hi,
   output logic        mtip
);

   localparam logic [1:0] SEL_CMP_LO  = 2'b00;
   localparam logic [1:0] SEL_CMP_HI  = 2'b01;
   localparam logic [1:0] SEL_TIME_HI = 2'b10;

   localparam logic [1:0] MODE_READ  = 2'b00;
   localparam logic [1:0] MODE_WRITE = 2'b01;
   localparam logic [1:0] MODE_SET   = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   logic [31:0] cmp_lo_q, cmp_lo_d;
   logic [31:0] cmp_hi_q, cmp_hi_d;
   logic [31:0] time_hi_q, time_hi_d;
   logic        carry_prev_q;
   logic        mtip_q, mtip_d;

   logic        wrap;
   logic        csr_upd;
   logic        cmp_upd;
   logic [31:0] cur_val;
   logic [31:0] new_val;
   logic        cmp_ge;

   // The low counter's carry toggles once per wrap, so any change is a wrap.
   assign wrap = time_carry ^ carry_prev_q;

   always_comb begin
      cur_val = 32'h0;
      case (csr_sel)
         SEL_CMP_LO:  cur_val = cmp_lo_q;
         SEL_CMP_HI:  cur_val = cmp_hi_q;
         SEL_TIME_HI: cur_val = time_hi_q;
         default:     cur_val = 32'h0;
      endcase
   end

   always_comb begin
      new_val = cur_val;
      case (rw_mode)
         MODE_WRITE: new_val = d;
         MODE_SET:   new_val = cur_val | d;
         MODE_CLEAR: new_val = cur_val & ~d;
         default:    new_val = cur_val;
      endcase
   end

   assign csr_upd = csr_en && (rw_mode != MODE_READ) && (csr_sel != 2'b11);
   assign cmp_upd = csr_upd && ((csr_sel == SEL_CMP_LO) || (csr_sel == SEL_CMP_HI));

   always_comb begin
      cmp_lo_d  = cmp_lo_q;
      cmp_hi_d  = cmp_hi_q;
      time_hi_d = time_hi_q;
      if (wrap) begin
         time_hi_d = time_hi_q + 32'd1;
      end
      // A software write to time_hi overrides the same-edge wrap increment.
      if (csr_upd) begin
         case (csr_sel)
            SEL_CMP_LO:  cmp_lo_d  = new_val;
            SEL_CMP_HI:  cmp_hi_d  = new_val;
            SEL_TIME_HI: time_hi_d = new_val;
            default:     ;
         endcase
      end
   end

   assign cmp_ge = ({time_hi_q, time_lo} >= {cmp_hi_q, cmp_lo_q});

   // Changing the compare value masks the interrupt for one edge.
   assign mtip_d = cmp_upd ? 1'b0 : (irq_en & cmp_ge);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cmp_lo_q     <= 32'hFFFF_FFFF;
         cmp_hi_q     <= 32'hFFFF_FFFF;
         time_hi_q    <= 32'h0;
         carry_prev_q <= 1'b0;
         mtip_q       <= 1'b0;
      end else begin
         cmp_lo_q     <= cmp_lo_d;
         cmp_hi_q     <= cmp_hi_d;
         time_hi_q    <= time_hi_d;
         carry_prev_q <= time_carry;
         mtip_q       <= mtip_d;
      end
   end

   assign qo      = cur_val;
   assign time_hi = time_hi_q;
   assign mtip    = mtip_q;

endmodule

// File: tb/tb_timer_cmp.sv
// Directed vector table for timer_cmp: qo is checked before each edge,
// time_hi and mtip after it through a scoreboard queue.
module tb_timer_cmp;

   logic        clk;
   logic        nreset;
   logic [31:0] time_lo;
   logic        time_carry;
   logic        csr_en;
   logic [1:0]  csr_sel;
   logic [1:0]  rw_mode;
   logic [31:0] d;
   logic        irq_en;
   logic [31:0] qo;
   logic [31:0] time_hi;
   logic        mtip;

   timer_cmp dut (
      .clk        (clk),
      .nreset     (nreset),
      .time_lo    (time_lo),
      .time_carry (time_carry),
      .csr_en     (csr_en),
      .csr_sel    (csr_sel),
      .rw_mode    (rw_mode),
      .d          (d),
      .irq_en     (irq_en),
      .qo         (qo),
      .time_hi    (time_hi),
      .mtip       (mtip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [1:0]  sel;
      logic [1:0]  mode;
      logic [31:0] d;
      logic [31:0] lo;
      logic        carry;
      logic        irq;
      logic [31:0] exp_qo;
      logic [31:0] exp_hi;
      logic        exp_mtip;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] hi;
      logic        mtip;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(logic en, logic [1:0] sel, logic [1:0] mode, logic [31:0] dv,
                               logic [31:0] lo, logic carry, logic irq,
                               logic [31:0] eq, logic [31:0] eh, logic em);
      vec_t v;
      v.en = en; v.sel = sel; v.mode = mode; v.d = dv; v.lo = lo; v.carry = carry;
      v.irq = irq; v.exp_qo = eq; v.exp_hi = eh; v.exp_mtip = em;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h want %h", name, idx, got, exp);
      end
   endtask

   initial begin
      sb_t e;
      nreset = 1'b0; time_lo = 32'h0; time_carry = 1'b0; csr_en = 1'b0;
      csr_sel = 2'b00; rw_mode = 2'b00; d = 32'h0; irq_en = 1'b0;

      //   en sel    mode   d             lo            cy irq  exp_qo        exp_hi        mtip
      // reset values through qo
      add(0, 2'd0, 2'd0, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFF, 32'h0,        0);
      add(0, 2'd1, 2'd0, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFF, 32'h0,        0);
      add(0, 2'd2, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0);
      add(0, 2'd3, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0);
      // carry toggles increment time_hi, a held carry does not
      add(0, 2'd2, 2'd0, 32'h0,        32'hFFFFFFFF, 1, 0, 32'h0,        32'h1,        0);
      add(0, 2'd2, 2'd0, 32'h0,        32'h0,        1, 0, 32'h1,        32'h1,        0);
      add(0, 2'd2, 2'd0, 32'h0,        32'h5,        1, 0, 32'h1,        32'h1,        0);
      add(0, 2'd2, 2'd0, 32'h0,        32'hFFFFFFFF, 0, 0, 32'h1,        32'h2,        0);
      add(0, 2'd2, 2'd0, 32'h0,        32'h0,        0, 0, 32'h2,        32'h2,        0);
      // program compare = 0x0000_0000_0000_0010, time_hi = 0
      add(1, 2'd1, 2'd1, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFF, 32'h2,        0);
      add(1, 2'd2, 2'd1, 32'h0,        32'h0,        0, 0, 32'h2,        32'h0,        0);
      add(1, 2'd0, 2'd1, 32'h10,       32'h0,        0, 0, 32'hFFFFFFFF, 32'h0,        0);
      // time_lo ramps through the compare value
      add(0, 2'd0, 2'd0, 32'h0,        32'hE,        0, 1, 32'h10,       32'h0,        0);
      add(0, 2'd0, 2'd0, 32'h0,        32'hF,        0, 1, 32'h10,       32'h0,        0);
      add(0, 2'd0, 2'd0, 32'h0,        32'h10,       0, 1, 32'h10,       32'h0,        1);
      add(0, 2'd0, 2'd0, 32'h0,        32'h11,       0, 1, 32'h10,       32'h0,        1);
      // set then clear bit 0 of cmp_hi
      add(1, 2'd1, 2'd2, 32'h1,        32'h12,       0, 1, 32'h0,        32'h0,        0);
      add(0, 2'd1, 2'd0, 32'h0,        32'h13,       0, 1, 32'h1,        32'h0,        0);
      add(1, 2'd1, 2'd3, 32'h1,        32'h13,       0, 1, 32'h1,        32'h0,        0);
      add(0, 2'd1, 2'd0, 32'h0,        32'h14,       0, 1, 32'h0,        32'h0,        1);
      // cmp_lo write while condition stays true masks one edge only
      add(1, 2'd0, 2'd1, 32'h14,       32'h15,       0, 1, 32'h10,       32'h0,        0);
      add(0, 2'd0, 2'd0, 32'h0,        32'h16,       0, 1, 32'h14,       32'h0,        1);
      // read mode and reserved select change nothing
      add(1, 2'd0, 2'd0, 32'h0,        32'h16,       0, 1, 32'h14,       32'h0,        1);
      add(0, 2'd0, 2'd0, 32'h0,        32'h16,       0, 1, 32'h14,       32'h0,        1);
      add(1, 2'd3, 2'd1, 32'h0,        32'h16,       0, 1, 32'h0,        32'h0,        1);
      // time_hi write on a wrap edge wins over the increment
      add(1, 2'd2, 2'd1, 32'h1234,     32'hFFFFFFFF, 1, 1, 32'h0,        32'h1234,     1);
      add(0, 2'd2, 2'd0, 32'h0,        32'h0,        1, 1, 32'h1234,     32'h1234,     1);
      add(0, 2'd2, 2'd0, 32'h0,        32'h0,        1, 0, 32'h1234,     32'h1234,     0);
      add(1, 2'd2, 2'd2, 32'h10000,    32'h0,        1, 0, 32'h1234,     32'h11234,    0);
      // time_hi wraps silently
      add(1, 2'd2, 2'd1, 32'hFFFFFFFF, 32'h0,        1, 0, 32'h11234,    32'hFFFFFFFF, 0);
      add(0, 2'd2, 2'd0, 32'h0,        32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'h0,        0);
      add(0, 2'd2, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         csr_en = vecs[i].en; csr_sel = vecs[i].sel; rw_mode = vecs[i].mode;
         d = vecs[i].d; time_lo = vecs[i].lo; time_carry = vecs[i].carry; irq_en = vecs[i].irq;
         #1;
         chk("qo", i, qo, vecs[i].exp_qo);
         e.idx = i; e.hi = vecs[i].exp_hi; e.mtip = vecs[i].exp_mtip;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            chk("scoreboard_empty", i, 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("time_hi", e.idx, time_hi, e.hi);
            chk("mtip", e.idx, {31'h0, mtip}, {31'h0, e.mtip});
         end
         $display("step %0d en=%0d sel=%0d mode=%0d d=%h lo=%h cy=%0d irq=%0d -> qo=%h hi=%h mtip=%0d",
                  i, vecs[i].en, vecs[i].sel, vecs[i].mode, vecs[i].d, vecs[i].lo,
                  vecs[i].carry, vecs[i].irq, qo, time_hi, mtip);
      end

      // Asynchronous reset in the middle of a cmp_lo write with mtip set
      @(negedge clk);
      csr_en = 1'b0; csr_sel = 2'd0; rw_mode = 2'd0; time_lo = 32'h100; irq_en = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_reset_mtip", 100, {31'h0, mtip}, 32'h1);
      @(negedge clk);
      csr_en = 1'b1; rw_mode = 2'd1; d = 32'h55;
      #2;
      nreset = 1'b0;
      #1;
      chk("async_cmp_lo", 101, qo, 32'hFFFFFFFF);
      chk("async_mtip", 101, {31'h0, mtip}, 32'h0);
      chk("async_time_hi", 101, time_hi, 32'h0);
      @(posedge clk);
      #1;
      chk("held_cmp_lo", 102, qo, 32'hFFFFFFFF);
      chk("held_mtip", 102, {31'h0, mtip}, 32'h0);
      $display("reset step: qo=%h hi=%h mtip=%0d", qo, time_hi, mtip);
      @(negedge clk);
      csr_en = 1'b0; time_carry = 1'b0; time_lo = 32'h0;
      nreset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_time_hi", 103, time_hi, 32'h0);
      chk("post_reset_mtip", 103, {31'h0, mtip}, 32'h0);
      $display("post-reset step: qo=%h hi=%h mtip=%0d", qo, time_hi, mtip);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
